// File: rtl/merge_output_writer_pkg.sv
// Shared definitions for the merge-sort output writer: FSM encoding and line geometry.
package merge_output_writer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } wr_state_e;

    localparam int unsigned DefaultLineWidth = 512;

    function automatic int unsigned line_bytes(input int unsigned line_width);
        return line_width / 8;
    endfunction

    localparam int unsigned LINE_BYTES = line_bytes(DefaultLineWidth);

endpackage

// File: rtl/line_fifo.sv
// Synchronous line buffer with full/empty flags; enqueue and dequeue may coincide when full.
module line_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] deq_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_enq, do_deq;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PtrW + 1)'(DEPTH));
    assign do_deq   = deq & ~empty;
    assign do_enq   = enq & (~full | do_deq);
    assign deq_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_enq) begin
                mem_q[wr_ptr_q] <= enq_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/merge_output_writer.sv
// Packs pairs of 8-record tuples from the merger root into memory lines and writes them
// out sequentially from a base address.
module merge_output_writer
    import merge_output_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [31:0]             i_num_lines,
    input  logic [8*DATA_WIDTH-1:0] i_data,
    input  logic                    i_write,
    output logic                    o_ready,
    output logic                    o_mem_valid,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [LINE_WIDTH-1:0]   o_mem_data,
    input  logic                    i_mem_ready,
    output logic                    o_busy,
    output logic                    o_done
);
    // Default geometry uses the shared constant; other widths derive it.
    localparam int unsigned LineBytes =
        (LINE_WIDTH == DefaultLineWidth) ? LINE_BYTES : line_bytes(LINE_WIDTH);

    wr_state_e               state_q, state_d;
    logic [31:0]             num_lines_q, packed_q, sent_q, sent_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    half_q;
    logic [8*DATA_WIDTH-1:0] low_q;
    logic                    fifo_full, fifo_empty;
    logic                    pop, accept, push, start_ok;

    assign start_ok    = (state_q == StIdle) & i_start;
    assign pop         = ~fifo_empty & i_mem_ready;
    assign o_ready     = (state_q == StRun) & (~(half_q & fifo_full) | pop);
    assign accept      = i_write & o_ready;
    assign push        = accept & half_q;
    assign sent_d      = sent_q + 32'(pop);
    assign o_mem_valid = ~fifo_empty;
    assign o_mem_addr  = addr_q;
    assign o_busy      = (state_q == StRun) | (state_q == StDrain);
    assign o_done      = (state_q == StDone);

    line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_WIDTH)
    ) u_line_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .enq      (push),
        .enq_data ({i_data, low_q}),
        .deq      (pop),
        .deq_data (o_mem_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = (i_num_lines == '0) ? StDone : StRun;
            StRun:   if (push && (packed_q + 32'd1 == num_lines_q)) state_d = StDrain;
            // Finish in the cycle after the last request handshake.
            StDrain: if (sent_d == num_lines_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            num_lines_q <= '0;
            packed_q    <= '0;
            sent_q      <= '0;
            addr_q      <= '0;
            half_q      <= 1'b0;
            low_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                num_lines_q <= i_num_lines;
                addr_q      <= i_base_addr;
                packed_q    <= '0;
                sent_q      <= '0;
                half_q      <= 1'b0;
            end else begin
                sent_q <= sent_d;
                if (pop) addr_q <= addr_q + ADDR_WIDTH'(LineBytes);
                if (accept) begin
                    if (!half_q) begin
                        low_q  <= i_data;
                        half_q <= 1'b1;
                    end else begin
                        half_q   <= 1'b0;
                        packed_q <= packed_q + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_merge_output_writer.sv
// Randomized bench for merge_output_writer with a queue-based line model and per-cycle compare.
module tb_merge_output_writer;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 512;
    localparam int unsigned AW = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            i_rst_n;
    logic            i_start;
    logic [AW-1:0]   i_base_addr;
    logic [31:0]     i_num_lines;
    logic [8*DW-1:0] i_data;
    logic            i_write;
    logic            o_ready;
    logic            o_mem_valid;
    logic [AW-1:0]   o_mem_addr;
    logic [LW-1:0]   o_mem_data;
    logic            i_mem_ready;
    logic            o_busy;
    logic            o_done;

    merge_output_writer #(
        .DATA_WIDTH (DW),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_lines (i_num_lines),
        .i_data      (i_data),
        .i_write     (i_write),
        .o_ready     (o_ready),
        .o_mem_valid (o_mem_valid),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .i_mem_ready (i_mem_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8*DW-1:0] rand_tuple();
        logic [8*DW-1:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } line_t;

    // Model: each pair of accepted tuples is one line, written in order to base + k*64.
    line_t           exp_q[$];
    bit              m_active = 0, m_half = 0;
    int              m_num = 0, m_acc = 0, m_sent = 0;
    logic [AW-1:0]   m_base;
    logic [8*DW-1:0] m_low;
    bit              exp_done_next = 0, exp_done_now;
    bit              prev_stall = 0, exp_ready;
    logic [AW-1:0]   prev_addr;
    logic [LW-1:0]   prev_data;
    int              cyc_n = 0, last_hs_cyc = 0, last_done_cyc = 0, last_start_cyc = 0;
    logic [AW-1:0]   hs_addr[$];
    logic [LW-1:0]   hs_data[$];
    logic [8*DW-1:0] tup_log[$];

    always @(negedge clk) begin
        line_t e;
        int occ;
        cyc_n++;
        if (!i_rst_n) begin
            exp_q.delete();
            m_active = 0; m_half = 0; m_acc = 0; m_sent = 0;
            exp_done_next = 0; prev_stall = 0;
        end else begin
            exp_done_now = exp_done_next;
            exp_done_next = 0;
            occ = exp_q.size();
            check("done", o_done, exp_done_now);
            check("busy", o_busy, m_active);
            check("mem_valid", o_mem_valid, occ > 0);
            exp_ready = m_active && (m_acc < 2 * m_num) &&
                        (!(m_half && occ == DEPTH) || (occ > 0 && i_mem_ready));
            check("ready", o_ready, exp_ready);
            if (prev_stall) begin
                check("hold_addr", o_mem_addr, prev_addr);
                check("hold_data", o_mem_data, prev_data);
            end
            prev_stall = o_mem_valid && !i_mem_ready;
            prev_addr = o_mem_addr;
            prev_data = o_mem_data;
            if (o_mem_valid && i_mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_request: got addr %0h expected none", o_mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", o_mem_addr, e.addr);
                    check("req_data", o_mem_data, e.data);
                end
                hs_addr.push_back(o_mem_addr);
                hs_data.push_back(o_mem_data);
                last_hs_cyc = cyc_n;
                if (m_active) begin
                    m_sent++;
                    if (m_sent == m_num) begin
                        m_active = 0;
                        exp_done_next = 1;
                    end
                end
            end
            if (i_write && o_ready && m_active && m_acc < 2 * m_num) begin
                if (!m_half) begin
                    m_low = i_data;
                    m_half = 1;
                end else begin
                    e.addr = m_base + AW'((m_acc / 2) * 64);
                    e.data = {i_data, m_low};
                    exp_q.push_back(e);
                    m_half = 0;
                end
                m_acc++;
            end
            if (i_start && !m_active && !exp_done_now) begin
                last_start_cyc = cyc_n;
                if (i_num_lines == 0) exp_done_next = 1;
                else begin
                    m_active = 1; m_num = int'(i_num_lines); m_base = i_base_addr;
                    m_acc = 0; m_sent = 0; m_half = 0;
                end
            end
            if (o_done) last_done_cyc = cyc_n;
        end
    end

    task automatic clear_logs();
        hs_addr.delete();
        hs_data.delete();
        tup_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_mem_valid"}, o_mem_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_mem_addr"}, o_mem_addr, 0);
        check({tag, "_mem_data"}, o_mem_data, 0);
    endtask

    // hold: memory stalled for that many cycles; rst_after: reset once that many requests went out.
    task automatic run_job(input logic [31:0] base, input int lines, input int gap_pct,
                           input bit rand_ready, input int hold, input int rst_after,
                           input int mid_start);
        logic [8*DW-1:0] cur;
        int acc, cyc;
        bit done_seen;
        cur = rand_tuple(); acc = 0; cyc = 0;
        @(posedge clk); #1;
        i_start = 1; i_base_addr = base; i_num_lines = lines; i_write = 0; i_mem_ready = 1;
        @(posedge clk); #1;
        i_start = 0;
        while (acc < 2 * lines && cyc < 2000) begin
            i_write = ($urandom_range(99) >= gap_pct);
            i_data = cur;
            i_mem_ready = (cyc < hold) ? 1'b0 : (rand_ready ? 1'($urandom_range(1)) : 1'b1);
            i_start = (cyc == mid_start);
            if (cyc == mid_start) begin
                i_base_addr = 32'h5000;
                i_num_lines = 99;
            end
            @(negedge clk);
            if (i_write && o_ready) begin
                tup_log.push_back(cur);
                acc++;
                cur = rand_tuple();
            end
            if (hold > 0 && cyc == hold - 1) begin
                check("stall_accepted_tuples", acc, 9);
                check("stall_ready_low", o_ready, 0);
                check("stall_valid", o_mem_valid, 1);
            end
            if (rst_after > 0 && hs_addr.size() >= rst_after) begin
                i_write = 0;
                @(posedge clk); #3;
                i_rst_n = 0;
                #1;
                check_reset_outputs("midjob_reset");
                @(posedge clk);
                @(posedge clk); #1;
                i_rst_n = 1;
                return;
            end
            cyc++;
            @(posedge clk); #1;
        end
        i_write = 0; i_start = 0;
        if (acc < 2 * lines) begin
            n_cmp++; n_fail++;
            $display("FAIL tuple_budget: got %0d tuples expected %0d", acc, 2 * lines);
        end
        done_seen = 0; cyc = 0;
        while (!done_seen && cyc < 500) begin
            i_mem_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            done_seen = o_done;
            cyc++;
            if (!done_seen) begin
                @(posedge clk); #1;
            end
        end
        if (!done_seen) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 500 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] l;
        i_rst_n = 0; i_start = 0; i_base_addr = '0; i_num_lines = '0;
        i_data = '0; i_write = 0; i_mem_ready = 1;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        i_rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // Two lines, back-to-back tuples, memory always ready.
        clear_logs();
        run_job(32'h1000, 2, 0, 0, 0, 0, -1);
        check("basic_count", hs_addr.size(), 2);
        if (hs_addr.size() == 2) begin
            check("basic_addr0", hs_addr[0], 32'h1000);
            check("basic_addr1", hs_addr[1], 32'h1040);
            l = hs_data[0];
            check("basic_line0_low", l[255:0], tup_log[0]);
            check("basic_line0_high", l[511:256], tup_log[1]);
            l = hs_data[1];
            check("basic_line1_low", l[255:0], tup_log[2]);
        end
        check("basic_done_latency", last_done_cyc - last_hs_cyc, 1);

        // Memory stalled: four lines buffered, one half line held, then drain with no loss.
        clear_logs();
        run_job(32'h8000, 20, 0, 0, 30, 0, -1);
        check("stall_lines_total", hs_addr.size(), 20);

        // Empty job.
        clear_logs();
        run_job(32'h4000, 0, 0, 0, 0, 0, -1);
        check("zero_done_latency", last_done_cyc - last_start_cyc, 1);
        check("zero_no_requests", hs_addr.size(), 0);

        // Address wrap.
        clear_logs();
        run_job(32'hFFFF_FFC0, 2, 0, 0, 0, 0, -1);
        check("wrap_count", hs_addr.size(), 2);
        if (hs_addr.size() == 2) check("wrap_addr1", hs_addr[1], 32'h0);

        // Reset after three of six lines, then a clean job.
        clear_logs();
        run_job(32'h7000, 6, 0, 0, 0, 3, -1);
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        run_job(32'h2000, 4, 20, 1, 0, 0, -1);
        check("after_reset_count", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            check("after_reset_addr0", hs_addr[0], 32'h2000);
            check("after_reset_addr3", hs_addr[3], 32'h20C0);
        end

        // Start pulse during RUN is ignored.
        clear_logs();
        run_job(32'h3000, 4, 0, 0, 0, 0, 2);
        check("midstart_count", hs_addr.size(), 4);
        if (hs_addr.size() == 4) check("midstart_addr3", hs_addr[3], 32'h30C0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            clear_logs();
            run_job($urandom, int'($urandom_range(1, 10)), 30, 1, 0, 0, -1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
